// File: rtl/pipelined_cpa.sv
// Pipelined carry-propagate adder/subtractor.
// Each stage resolves one SEG-bit slice of the carry chain. Operand bits for
// the upper slices travel forward with the partial sum, so every bit of a
// result leaves the last stage on the same cycle. One global advance signal
// moves the whole pipeline or freezes it.
module pipelined_cpa #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    // WIDTH must be an integer multiple of SEG.
    localparam int STAGES = WIDTH / SEG;

    // One slice of the ripple chain: SEG-bit add with carry in, carry out on top.
    function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           c);
        return {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, c};
    endfunction

    // Pipeline state, one entry per stage. r_b holds the effective operand
    // (already inverted for subtract), so the mode needs no further tracking.
    logic [WIDTH-1:0]  r_a   [STAGES];
    logic [WIDTH-1:0]  r_b   [STAGES];
    logic [WIDTH-1:0]  r_sum [STAGES];
    logic              r_cry [STAGES];
    logic [STAGES-1:0] r_vld;
    logic              r_ovf;

    // Per-stage inputs (from the ports for stage 0, else from the prior stage)
    // and the next-state values each stage computes.
    logic [WIDTH-1:0]  w_src_a [STAGES];
    logic [WIDTH-1:0]  w_src_b [STAGES];
    logic [WIDTH-1:0]  w_src_s [STAGES];
    logic              w_src_c [STAGES];
    logic [SEG:0]      w_seg   [STAGES];
    logic [WIDTH-1:0]  w_nsum  [STAGES];
    logic              w_ncry  [STAGES];
    logic              w_novf;
    logic              w_adv;

    // Whole pipeline moves whenever the output slot is empty or being taken.
    assign w_adv     = !r_vld[STAGES-1] || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_vld[STAGES-1];
    assign sum       = r_sum[STAGES-1];
    assign cout      = r_cry[STAGES-1];
    assign ovf       = r_ovf;

    // Slice arithmetic: stage k fills bits [k*SEG +: SEG] of the partial sum.
    always_comb begin
        w_src_a[0] = a;
        w_src_b[0] = sub ? ~b : b;
        w_src_c[0] = cin ^ sub;
        w_src_s[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            w_src_a[k] = r_a[k-1];
            w_src_b[k] = r_b[k-1];
            w_src_c[k] = r_cry[k-1];
            w_src_s[k] = r_sum[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_seg[k]  = seg_add(w_src_a[k][k*SEG +: SEG], w_src_b[k][k*SEG +: SEG], w_src_c[k]);
            w_nsum[k] = w_src_s[k];
            w_nsum[k][k*SEG +: SEG] = w_seg[k][SEG-1:0];
            w_ncry[k] = w_seg[k][SEG];
        end
        // Signed overflow: effective operands agree in sign, result does not.
        w_novf = (w_src_a[STAGES-1][WIDTH-1] == w_src_b[STAGES-1][WIDTH-1]) &&
                 (w_nsum[STAGES-1][WIDTH-1] != w_src_a[STAGES-1][WIDTH-1]);
    end

    // Shift every stage together on advance; reset clears valids and the visible outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld           <= '0;
            r_sum[STAGES-1] <= '0;
            r_cry[STAGES-1] <= 1'b0;
            r_ovf           <= 1'b0;
        end else if (w_adv) begin
            r_vld[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]   <= w_src_a[k];
                r_b[k]   <= w_src_b[k];
                r_sum[k] <= w_nsum[k];
                r_cry[k] <= w_ncry[k];
            end
            r_ovf <= w_novf;
        end
    end

endmodule

// File: tb/tb_pipelined_cpa.sv
// Testbench for pipelined_cpa (WIDTH=16, SEG=4): directed table, stall,
// mid-flight reset and a randomized stream against an arithmetic model.
module tb_pipelined_cpa;
    localparam int WIDTH  = 16;
    localparam int SEG    = 4;
    localparam int STAGES = WIDTH / SEG;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    always #5 clk = ~clk;

    pipelined_cpa #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        ov;
    } res_t;

    int   n_pass  = 0;
    int   n_total = 0;
    int   n_acc   = 0;
    int   n_deliv = 0;
    res_t expq[$];

    // Reference: plain integer arithmetic on the operand values.
    function automatic res_t model(input logic [15:0] ia, input logic [15:0] ib,
                                   input logic icin, input logic isub);
        res_t        r;
        int unsigned u;
        int          sv;
        if (!isub) begin
            u  = 32'(ia) + 32'(ib) + 32'(icin);
            sv = int'($signed(ia)) + int'($signed(ib)) + int'(icin);
        end else begin
            u  = 32'(ia) + 32'h10000 - 32'(ib) - 32'(icin);
            sv = int'($signed(ia)) - int'($signed(ib)) - int'(icin);
        end
        r.s  = u[15:0];
        r.co = u[16];
        r.ov = (sv > 32767) || (sv < -32768);
        return r;
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle of stream stimulus and score any transfers before the edge.
    task automatic drive(input logic iv, input logic orr, input logic [15:0] ia,
                         input logic [15:0] ib, input logic icin, input logic isub);
        in_valid  = iv;
        out_ready = orr;
        a         = ia;
        b         = ib;
        cin       = icin;
        sub       = isub;
        #1;
        if (out_valid && out_ready) begin
            n_deliv++;
            if (expq.size() == 0) begin
                check("stream_spurious", 32'(out_valid), 32'd0);
            end else begin
                res_t e;
                e = expq.pop_front();
                check("stream_result", {14'd0, sum, cout, ovf}, {14'd0, e.s, e.co, e.ov});
            end
        end
        if (in_valid && in_ready) begin
            expq.push_back(model(ia, ib, icin, isub));
            n_acc++;
        end
    endtask

    // Single operand with out_ready=1: measure latency and compare the result.
    task automatic run_vec(input vec_t v, input string nm);
        int lat;
        a = v.a; b = v.b; cin = v.cin; sub = v.sub;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        a = ~v.a; b = ~v.b; cin = ~v.cin; sub = ~v.sub;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({nm, "_latency"}, 32'(lat), 32'(STAGES));
        check({nm, "_result"}, {14'd0, sum, cout, ovf}, {14'd0, v.s, v.co, v.ov});
        step();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        logic [17:0] hold;
        vecs[0] = '{16'h0001, 16'h0003, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h0003, 16'h0001, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};

        // Reset with an operand presented on the reset edges.
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
        step();
        step();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // Directed table; the first entry is accepted on the first edge out of reset.
        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Eight back-to-back operands with out_ready low for three cycles.
        n_acc = 0; n_deliv = 0; hold = '0;
        for (int c = 0; c < 40 && n_deliv < 8; c++) begin
            logic orr;
            orr = !(c >= 5 && c < 8);
            drive(n_acc < 8, orr, pick(), pick(), 1'($urandom), 1'($urandom));
            if (!orr) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                if (c == 5) begin
                    check("stall_out_valid", 32'(out_valid), 32'd1);
                    hold = {sum, cout, ovf};
                end else begin
                    check("stall_hold", {14'd0, sum, cout, ovf}, {14'd0, hold});
                end
            end
            step();
        end
        check("stall_delivered", 32'(n_deliv), 32'd8);
        check("stall_queue_empty", 32'(expq.size()), 32'd0);

        // Three in flight, then a one-cycle reset.
        in_valid = 1'b1; out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 16'h0100 * 16'(i + 1); b = 16'h0011;
            step();
        end
        rst_n = 1'b0; a = 16'h0F0F; b = 16'h0F0F;
        step();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        begin
            res_t e;
            int   lat;
            int   extra;
            a = 16'h0123; b = 16'h0456; cin = 1'b1; sub = 1'b1;
            e = model(16'h0123, 16'h0456, 1'b1, 1'b1);
            step();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                step();
                lat++;
            end
            check("midrst_latency", 32'(lat), 32'(STAGES));
            check("midrst_result", {14'd0, sum, cout, ovf}, {14'd0, e.s, e.co, e.ov});
            extra = 0;
            for (int i = 0; i < 8; i++) begin
                step();
                if (out_valid) extra++;
            end
            check("midrst_no_stale", 32'(extra), 32'd0);
        end
        expq.delete();

        // Randomized stream with random valid/ready.
        n_acc = 0; n_deliv = 0;
        for (int c = 0; c < 60000 && n_deliv < 10000; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  pick(), pick(), 1'($urandom), 1'($urandom));
            step();
        end
        check("rand_delivered", 32'(n_deliv >= 10000), 32'd1);
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
            step();
        end
        check("rand_queue_empty", 32'(expq.size()), 32'd0);
        check("rand_acc_eq_deliv", 32'(n_acc), 32'(n_deliv));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
